apb_mem_slave_ws: RTL

Parametrised APB memory slave, next generation of the basic single-cycle APB slave. Adds configurable depth independent of address width, byte addressing with alignment/range checking, PSLVERR signalling and a programmable number of wait states, all driven by an explicit access FSM. Sits on the APB bus behind the bridge/decoder as a generic scratch RAM or register-file target.

---
 rtl/apb_slv_pkg.sv | 25 ++
 rtl/apb_slv_ram.sv | 39 +++
 rtl/apb_mem_slave_ws.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/apb_slv_pkg.sv
// Shared types and helpers for the APB wait-state memory slave.
// Optional privilege protection is enabled by defining APB_SLV_PROT_EN.
package apb_slv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } apb_state_e;

    localparam int CNT_W = 4;

    localparam int PPROT_PRIV_BIT   = 0;
    localparam int PPROT_NONSEC_BIT = 1;
    localparam int PPROT_INSTR_BIT  = 2;

    function automatic int strb_w(input int dw);
        return dw / 8;
    endfunction

    function automatic int off_w(input int dw);
        return (dw > 8) ? $clog2(dw / 8) : 0;
    endfunction

endpackage

// File: rtl/apb_slv_ram.sv
// DEPTH x DATAWIDTH storage with per-byte write enables and a registered read port.
// Contents are intentionally not reset.
module apb_slv_ram
    import apb_slv_pkg::*;
#(
    parameter int DEPTH     = 256,
    parameter int DATAWIDTH = 32,
    parameter int AW        = 8
) (
    input  logic                        clk_i,
    input  logic                        we_i,
    input  logic [DATAWIDTH/8-1:0]      be_i,
    input  logic                        re_i,
    input  logic [AW-1:0]               addr_i,
    input  logic [DATAWIDTH-1:0]        wdata_i,
    output logic [DATAWIDTH-1:0]        rdata_o
);

    localparam int STRB_W = strb_w(DATAWIDTH);

    logic [DATAWIDTH-1:0] mem_q [DEPTH];
    logic [DATAWIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/apb_mem_slave_ws.sv
// APB memory slave with programmable wait states, byte strobes and PSLVERR.
// Define APB_SLV_PROT_EN to add PPROT and privilege-protect the upper half of memory.
module apb_mem_slave_ws
    import apb_slv_pkg::*;
#(
    parameter int ADDWIDTH    = 12,
    parameter int DATAWIDTH   = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDWIDTH-1:0]     PADDR,
    input  logic [DATAWIDTH/8-1:0]  PSTRB,
    input  logic [DATAWIDTH-1:0]    PWDATA,
`ifdef APB_SLV_PROT_EN
    input  logic [2:0]              PPROT,
`endif
    output logic                    PREADY,
    output logic [DATAWIDTH-1:0]    PRDATA,
    output logic                    PSLVERR
);

    localparam int STRB_W = strb_w(DATAWIDTH);
    localparam int OFF_W  = off_w(DATAWIDTH);
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [ADDWIDTH:0]   DEPTH_L  = (ADDWIDTH+1)'(DEPTH);
    localparam logic [ADDWIDTH-1:0] OFF_MASK = ADDWIDTH'(STRB_W - 1);
    localparam logic [CNT_W-1:0]    WS_L     = CNT_W'(WAIT_STATES);

    apb_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 err_q;
    logic                 rd_ok_q;

    logic [ADDWIDTH:0]    idx_ext;
    logic                 misalign;
    logic                 range_err;
    logic                 prot_err;
    logic                 err_c;
    logic                 ready_c;
    logic                 enter_rdy;
    logic                 ram_we;
    logic                 ram_re;
    logic [DATAWIDTH-1:0] ram_rdata;

    // Address decode: PADDR is held stable from setup through completion.
    assign idx_ext   = {1'b0, PADDR} >> OFF_W;
    assign misalign  = (PADDR & OFF_MASK) != '0;
    assign range_err = idx_ext >= DEPTH_L;

`ifdef APB_SLV_PROT_EN
    localparam logic [ADDWIDTH:0] PRIV_BASE = (ADDWIDTH+1)'(DEPTH / 2);
    logic unused_pprot;
    assign unused_pprot = ^PPROT[PPROT_INSTR_BIT:PPROT_NONSEC_BIT];
    assign prot_err     = (idx_ext >= PRIV_BASE) && !PPROT[PPROT_PRIV_BIT];
`else
    assign prot_err = 1'b0;
`endif

    assign err_c   = misalign | range_err | prot_err;
    assign ready_c = (state_q == ACCESS) && (cnt_q == WS_L);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_d = ACCESS;
                    cnt_d   = '0;
                end
            end
            ACCESS: begin
                if (!PSEL || !PENABLE) begin
                    state_d = IDLE;
                end else if (cnt_q != WS_L) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (PSEL && !PENABLE) begin
                    state_d = ACCESS;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // The read and the error flag are captured on the edge that makes PREADY visible.
    assign enter_rdy = (state_d == ACCESS) && (cnt_d == WS_L);
    assign ram_re    = enter_rdy && !PWRITE && !err_c && !PRESET;
    assign ram_we    = ready_c && PSEL && PENABLE && PWRITE && !err_q && !PRESET;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rd_ok_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (enter_rdy) begin
                err_q   <= err_c;
                rd_ok_q <= !PWRITE && !err_c;
            end
        end
    end

    apb_slv_ram #(
        .DEPTH     (DEPTH),
        .DATAWIDTH (DATAWIDTH),
        .AW        (AW)
    ) u_ram (
        .clk_i   (PCLK),
        .we_i    (ram_we),
        .be_i    (PSTRB),
        .re_i    (ram_re),
        .addr_i  (idx_ext[AW-1:0]),
        .wdata_i (PWDATA),
        .rdata_o (ram_rdata)
    );

    assign PREADY  = ready_c;
    assign PRDATA  = (ready_c && rd_ok_q) ? ram_rdata : '0;
    assign PSLVERR = ready_c && err_q;

endmodule
